regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of writeback requesters (index 0 ALU, 1 LSU, 2 MULDIV, 3 NPU).
REQ-002 The block SHALL have parameter XLEN, default 64, giving the writeback data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have the following ports:
- wb_valid, input, NREQ, requester i has a result.
- wb_rd, input, NREQ x 5, destination register per requester.
- wb_data, input, NREQ x XLEN, result data per requester.
- wb_ready, output, NREQ, result i accepted this cycle.
- issue_valid, input, 1, the issue stage allocates a destination.
- issue_rd, input, 5, allocated destination.
- write_enable_a / write_addr_a / write_data_a, output, 1/5/XLEN, register-file write port A.
- write_enable_b / write_addr_b / write_data_b, output, 1/5/XLEN, register-file write port B.
- reg_pending_writes, output, 32, scoreboard with one bit per register.
- conflict_count, output, 16, saturating count of same-rd deferrals.

Function
REQ-005 Grants SHALL be combinational: wb_ready[i] = 1 in the same cycle requester i is selected, and the handshake completes when wb_valid[i] && wb_ready[i].
REQ-006 Each cycle, at most two requesters with rd != 0 SHALL be granted, chosen in round-robin order starting at pointer rr_ptr.
REQ-007 The first grantee in round-robin order SHALL drive port A and the second SHALL drive port B.
REQ-008 A valid request with rd == 0 SHALL be granted whenever it is reached in round-robin order, SHALL consume no write port, and SHALL produce no register write.
REQ-009 If the two candidates selected for the ports have the same rd, only the first SHALL be granted and the second SHALL be held; conflict_count SHALL then increment, saturating at 16'hFFFF.
REQ-010 The write-port outputs SHALL be registered, so a write appears exactly one cycle after its handshake; write_enable_x SHALL be 0 in any cycle with no corresponding grant.
REQ-011 rr_ptr SHALL advance to (index of last nonzero-rd grantee + 1) mod NREQ, and SHALL be unchanged when there are no grants.
REQ-012 The round-robin scheme SHALL guarantee that a continuously valid requester is granted within NREQ cycles.
REQ-013 issue_valid with issue_rd != 0 SHALL set reg_pending_writes[issue_rd] on the next edge.
REQ-014 A granted write with rd != 0 SHALL clear reg_pending_writes[rd] on the same edge that registers the port output.
REQ-015 If a set and a clear of the same register occur in one cycle, the set SHALL win, because the new allocation supersedes the old one.
REQ-016 reg_pending_writes[0] SHALL be constant 0.
REQ-017 A requester SHALL hold wb_rd and wb_data stable while wb_valid && !wb_ready; this is a protocol assumption checked by an assertion, not enforced by the block.

Reset
REQ-018 While rst_n = 0, all outputs SHALL be 0, including write_enable_a and write_enable_b, all addresses and data, reg_pending_writes, conflict_count and wb_ready.
REQ-019 While rst_n = 0, rr_ptr SHALL be 0.
REQ-020 A reset asserted mid-operation SHALL discard any in-flight registered write, so no write enable is seen after reset is asserted.
REQ-021 Deassertion of rst_n SHALL take effect on the first clk edge after release; no grant SHALL occur while rst_n = 0.

Structure
REQ-022 A shared package wb_pkg SHALL hold XLEN, NREQ, the requester index constants (WB_ALU, WB_LSU, WB_MULDIV, WB_NPU) and the register-index type.
REQ-023 The round-robin two-grant picker SHALL be a sub-module named rr_dual_picker, taking valid, rd and rr_ptr and producing grant masks and port selects.
REQ-024 The scoreboard and the output registers SHALL remain in regfile_wb_arbiter.

Verification
REQ-025 Reset scenario: with rr_ptr = 0, drive ALU rd = 5, data = 0xAA and LSU rd = 7, data = 0xBB in one cycle -> next cycle port A writes x5 = 0xAA, port B writes x7 = 0xBB, and rr_ptr becomes 2.
REQ-026 Same-rd conflict: drive ALU and NPU both with rd = 9 -> ALU is granted first, NPU is held one cycle and then written, and conflict_count = 1.
REQ-027 Scoreboard set-and-clear collision: issue_rd = 12 while a grant writes rd = 12 in the same cycle -> reg_pending_writes[12] = 1 afterwards.
REQ-028 x0 request: drive MULDIV with rd = 0 alone -> wb_ready[2] = 1, with no write enable on either port in the following cycle.
REQ-029 Fairness: hold all four requesters valid with distinct rd for 8 cycles -> each is granted exactly 4 times and no wait exceeds 2 cycles.
REQ-030 Reset mid-operation: assert rst_n = 0 on the cycle after a grant -> write_enable_a = 0 immediately, and reg_pending_writes and conflict_count are 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-arbiter constants and types.
package wb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREGS = 32;

    localparam int unsigned WB_ALU    = 0;
    localparam int unsigned WB_LSU    = 1;
    localparam int unsigned WB_MULDIV = 2;
    localparam int unsigned WB_NPU    = 3;

    typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_dual_picker.sv
// Round-robin picker granting up to two nonzero-rd requesters per cycle;
// rd==0 requests are always granted and take no port.
module rr_dual_picker
    import wb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  reg_idx_t [N-1:0] rd,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N-1:0]     grant_c,
    output logic             sel_a_vld_c,
    output logic [PW-1:0]    sel_a_c,
    output logic             sel_b_vld_c,
    output logic [PW-1:0]    sel_b_c,
    output logic             conflict_c
);

    logic [PW-1:0] idx;
    logic          done;
    reg_idx_t      a_rd;

    // A same-rd second candidate stops the scan so the held requester heads the next cycle.
    always_comb begin
        grant_c     = '0;
        sel_a_vld_c = 1'b0;
        sel_a_c     = '0;
        sel_b_vld_c = 1'b0;
        sel_b_c     = '0;
        conflict_c  = 1'b0;
        done        = 1'b0;
        a_rd        = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(rr_ptr) + k) % N);
            if (valid[idx]) begin
                if (rd[idx] == '0) begin
                    grant_c[idx] = 1'b1;
                end else if (!done) begin
                    if (!sel_a_vld_c) begin
                        sel_a_vld_c  = 1'b1;
                        sel_a_c      = idx;
                        a_rd         = rd[idx];
                        grant_c[idx] = 1'b1;
                    end else if (rd[idx] == a_rd) begin
                        conflict_c = 1'b1;
                        done       = 1'b1;
                    end else begin
                        sel_b_vld_c  = 1'b1;
                        sel_b_c      = idx;
                        grant_c[idx] = 1'b1;
                        done         = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Dual-port register-file writeback arbiter with pending-write scoreboard
// and saturating same-rd conflict counter.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NREQ = wb_pkg::NREQ,
    parameter int unsigned XLEN = wb_pkg::XLEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           wb_valid,
    input  logic [NREQ-1:0][REG_W-1:0] wb_rd,
    input  logic [NREQ-1:0][XLEN-1:0] wb_data,
    output logic [NREQ-1:0]           wb_ready,
    input  logic                      issue_valid,
    input  logic [REG_W-1:0]          issue_rd,
    output logic                      write_enable_a,
    output logic [REG_W-1:0]          write_addr_a,
    output logic [XLEN-1:0]           write_data_a,
    output logic                      write_enable_b,
    output logic [REG_W-1:0]          write_addr_b,
    output logic [XLEN-1:0]           write_data_b,
    output logic [NREGS-1:0]          reg_pending_writes,
    output logic [15:0]               conflict_count
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req_vld;
    logic [NREQ-1:0]  grant;
    logic             sel_a_vld, sel_b_vld, conflict;
    logic [PW-1:0]    sel_a, sel_b;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             we_a_q, we_a_d, we_b_q, we_b_d;
    reg_idx_t         addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [XLEN-1:0]  data_a_q, data_a_d, data_b_q, data_b_d;
    logic [NREGS-1:0] pend_q, pend_d, pend_set, pend_clr;
    logic [15:0]      cnt_q, cnt_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (32'(x) == NREQ - 1) ? '0 : x + PW'(1);
    endfunction

    // No grant may occur while reset is asserted.
    assign req_vld = wb_valid & {NREQ{rst_n}};

    rr_dual_picker #(.N(NREQ)) u_picker (
        .valid       (req_vld),
        .rd          (wb_rd),
        .rr_ptr      (rr_ptr_q),
        .grant_c     (grant),
        .sel_a_vld_c (sel_a_vld),
        .sel_a_c     (sel_a),
        .sel_b_vld_c (sel_b_vld),
        .sel_b_c     (sel_b),
        .conflict_c  (conflict)
    );

    assign wb_ready = grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_a_d   = sel_a_vld;
        addr_a_d = sel_a_vld ? wb_rd[sel_a] : '0;
        data_a_d = sel_a_vld ? wb_data[sel_a] : '0;
        we_b_d   = sel_b_vld;
        addr_b_d = sel_b_vld ? wb_rd[sel_b] : '0;
        data_b_d = sel_b_vld ? wb_data[sel_b] : '0;
        pend_set = '0;
        pend_clr = '0;
        cnt_d    = cnt_q;

        if (sel_b_vld) begin
            rr_ptr_d = wrap_inc(sel_b);
        end else if (sel_a_vld) begin
            rr_ptr_d = wrap_inc(sel_a);
        end

        if (sel_a_vld) pend_clr[wb_rd[sel_a]] = 1'b1;
        if (sel_b_vld) pend_clr[wb_rd[sel_b]] = 1'b1;
        if (issue_valid) pend_set[issue_rd] = 1'b1;
        // A new allocation supersedes the retiring write to the same register.
        pend_d    = (pend_q & ~pend_clr) | pend_set;
        pend_d[0] = 1'b0;

        if (conflict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            we_a_q   <= 1'b0;
            addr_a_q <= '0;
            data_a_q <= '0;
            we_b_q   <= 1'b0;
            addr_b_q <= '0;
            data_b_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_a_q   <= we_a_d;
            addr_a_q <= addr_a_d;
            data_a_q <= data_a_d;
            we_b_q   <= we_b_d;
            addr_b_q <= addr_b_d;
            data_b_q <= data_b_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign write_enable_a     = we_a_q;
    assign write_addr_a       = addr_a_q;
    assign write_data_a       = data_a_q;
    assign write_enable_b     = we_b_q;
    assign write_addr_b       = addr_b_q;
    assign write_data_b       = data_b_q;
    assign reg_pending_writes = pend_q;
    assign conflict_count     = cnt_q;

    // Requesters must hold their payload while waiting for a grant.
    for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
        assert property (@(posedge clk) disable iff (!rst_n)
            (wb_valid[i] && !wb_ready[i]) |=>
            (!wb_valid[i] || ($stable(wb_rd[i]) && $stable(wb_data[i]))));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued at drive
// time and retired by a port monitor when the DUT writes.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       wb_valid;
    logic [3:0][4:0]  wb_rd;
    logic [3:0][63:0] wb_data;
    logic [3:0]       wb_ready;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             write_enable_a, write_enable_b;
    logic [4:0]       write_addr_a, write_addr_b;
    logic [63:0]      write_data_a, write_data_b;
    logic [31:0]      reg_pending_writes;
    logic [15:0]      conflict_count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t mon_a, mon_b;
    int  errors = 0;
    int  checks = 0;

    regfile_wb_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .wb_ready           (wb_ready),
        .issue_valid        (issue_valid),
        .issue_rd           (issue_rd),
        .write_enable_a     (write_enable_a),
        .write_addr_a       (write_addr_a),
        .write_data_a       (write_data_a),
        .write_enable_b     (write_enable_b),
        .write_addr_b       (write_addr_b),
        .write_data_b       (write_data_b),
        .reg_pending_writes (reg_pending_writes),
        .conflict_count     (conflict_count)
    );

    always #5 clk = ~clk;

    // Retire each observed register write against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_enable_a) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL port_a_unexpected: got x%0d=%h, required no write", write_addr_a, write_data_a);
                end else begin
                    mon_a = exp_a.pop_front();
                    if (write_addr_a !== mon_a.rd || write_data_a !== mon_a.data) begin
                        errors++;
                        $display("FAIL port_a_write: got x%0d=%h, required x%0d=%h", write_addr_a, write_data_a, mon_a.rd, mon_a.data);
                    end
                end
            end
            if (write_enable_b) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL port_b_unexpected: got x%0d=%h, required no write", write_addr_b, write_data_b);
                end else begin
                    mon_b = exp_b.pop_front();
                    if (write_addr_b !== mon_b.rd || write_data_b !== mon_b.data) begin
                        errors++;
                        $display("FAIL port_b_write: got x%0d=%h, required x%0d=%h", write_addr_b, write_data_b, mon_b.rd, mon_b.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [4:0] rd, input logic [63:0] data);
        wb_valid[i] = 1'b1;
        wb_rd[i]    = rd;
        wb_data[i]  = data;
    endtask

    task automatic test_reset();
        wb_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wb_rd[i]   = 5'(i + 1);
            wb_data[i] = 64'(i + 16);
        end
        #1;
        checks++;
        if (wb_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0000", wb_ready);
        end
        checks++;
        if ({write_enable_a, write_addr_a, write_data_a, write_enable_b, write_addr_b, write_data_b} !== '0) begin
            errors++;
            $display("FAIL reset_ports: got we_a=%b a=%0d we_b=%b b=%0d, required all 0", write_enable_a, write_addr_a, write_enable_b, write_addr_b);
        end
        checks++;
        if (reg_pending_writes !== 32'd0 || conflict_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got pend=%h cnt=%0d, required 0/0", reg_pending_writes, conflict_count);
        end
        wb_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_grant();
        drive(WB_ALU, 5'd5, 64'hAA);
        drive(WB_LSU, 5'd7, 64'hBB);
        exp_a.push_back('{rd: 5'd5, data: 64'hAA});
        exp_b.push_back('{rd: 5'd7, data: 64'hBB});
        #1;
        checks++;
        if (wb_ready !== 4'b0011) begin
            errors++;
            $display("FAIL dual_ready: got %b, required 0011", wb_ready);
        end
        tick();
        wb_valid = '0;
        // Pointer should now sit at MULDIV.
        for (int i = 0; i < 4; i++) drive(i, 5'(i + 1), 64'(8'hC0 + i));
        exp_a.push_back('{rd: 5'd3, data: 64'hC2});
        exp_b.push_back('{rd: 5'd4, data: 64'hC3});
        #1;
        checks++;
        if (wb_ready !== 4'b1100) begin
            errors++;
            $display("FAIL rr_ptr_two: got %b, required 1100", wb_ready);
        end
        tick();
        wb_valid = '0;
        tick();
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL dual_drain: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_conflict();
        drive(WB_ALU, 5'd9, 64'h11);
        drive(WB_NPU, 5'd9, 64'h33);
        exp_a.push_back('{rd: 5'd9, data: 64'h11});
        #1;
        checks++;
        if (wb_ready !== 4'b0001) begin
            errors++;
            $display("FAIL conflict_first: got %b, required 0001", wb_ready);
        end
        tick();
        wb_valid[WB_ALU] = 1'b0;
        exp_a.push_back('{rd: 5'd9, data: 64'h33});
        #1;
        checks++;
        if (wb_ready !== 4'b1000) begin
            errors++;
            $display("FAIL conflict_held: got %b, required 1000", wb_ready);
        end
        tick();
        wb_valid = '0;
        tick();
        checks++;
        if (conflict_count !== 16'd1) begin
            errors++;
            $display("FAIL conflict_count: got %0d, required 1", conflict_count);
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL conflict_drain: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_pending();
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (reg_pending_writes !== 32'h0000_1000) begin
            errors++;
            $display("FAIL pend_set: got %h, required 00001000", reg_pending_writes);
        end
        issue_valid = 1'b1;
        drive(WB_ALU, 5'd12, 64'h0C);
        exp_a.push_back('{rd: 5'd12, data: 64'h0C});
        tick();
        issue_valid = 1'b0;
        wb_valid    = '0;
        checks++;
        if (reg_pending_writes !== 32'h0000_1000) begin
            errors++;
            $display("FAIL pend_collision: got %h, required 00001000", reg_pending_writes);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        drive(WB_LSU, 5'd12, 64'h0D);
        exp_a.push_back('{rd: 5'd12, data: 64'h0D});
        #1;
        checks++;
        if (wb_ready !== 4'b0010) begin
            errors++;
            $display("FAIL pend_lsu_ready: got %b, required 0010", wb_ready);
        end
        tick();
        issue_valid = 1'b0;
        wb_valid    = '0;
        checks++;
        if (reg_pending_writes !== 32'h0) begin
            errors++;
            $display("FAIL pend_clear: got %h, required 00000000", reg_pending_writes);
        end
        tick();
    endtask

    task automatic test_x0();
        drive(WB_MULDIV, 5'd0, 64'hEE);
        #1;
        checks++;
        if (wb_ready !== 4'b0100) begin
            errors++;
            $display("FAIL x0_ready: got %b, required 0100", wb_ready);
        end
        tick();
        wb_valid = '0;
        tick();
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL x0_drain: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_fairness();
        int cnt[4];
        int wait_c[4];
        int max_wait;
        logic [3:0] exp_rdy;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i]    = 0;
            wait_c[i] = 0;
            drive(i, 5'(20 + i), 64'(16'hF000 + i));
        end
        // Pointer is at MULDIV after the x0 request left it untouched.
        for (int c = 0; c < 8; c++) begin
            exp_rdy = (c % 2 == 0) ? 4'b1100 : 4'b0011;
            if (c % 2 == 0) begin
                exp_a.push_back('{rd: 5'd22, data: 64'hF002});
                exp_b.push_back('{rd: 5'd23, data: 64'hF003});
            end else begin
                exp_a.push_back('{rd: 5'd20, data: 64'hF000});
                exp_b.push_back('{rd: 5'd21, data: 64'hF001});
            end
            #1;
            checks++;
            if (wb_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fair_cycle%0d: got %b, required %b", c, wb_ready, exp_rdy);
            end
            for (int i = 0; i < 4; i++) begin
                if (wb_ready[i]) begin
                    cnt[i]++;
                    wait_c[i] = 0;
                end else begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
            end
            tick();
        end
        wb_valid = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] != 4) begin
                errors++;
                $display("FAIL fair_count%0d: got %0d, required 4", i, cnt[i]);
            end
        end
        checks++;
        if (max_wait > 2) begin
            errors++;
            $display("FAIL fair_wait: got %0d, required <= 2", max_wait);
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL fair_drain: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(WB_ALU, 5'd20, 64'h55);
        issue_valid = 1'b1;
        issue_rd    = 5'd21;
        tick();
        wb_valid    = '0;
        issue_valid = 1'b0;
        checks++;
        if (write_enable_a !== 1'b1 || write_addr_a !== 5'd20 || write_data_a !== 64'h55) begin
            errors++;
            $display("FAIL mid_write: got we=%b x%0d=%h, required 1 x20=55", write_enable_a, write_addr_a, write_data_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (write_enable_a !== 1'b0 || write_enable_b !== 1'b0) begin
            errors++;
            $display("FAIL mid_we: got a=%b b=%b, required 0/0", write_enable_a, write_enable_b);
        end
        checks++;
        if (reg_pending_writes !== 32'd0 || conflict_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_state: got pend=%h cnt=%0d, required 0/0", reg_pending_writes, conflict_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        wb_valid    = '0;
        wb_rd       = '0;
        wb_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        tick();
        tick();
        test_reset();
        test_dual_grant();
        test_conflict();
        test_pending();
        test_x0();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
